// File: rtl/dev_pic.sv
// Six-line interrupt aggregator: 2-edge input sync, edge/level pending latch, mask + global enable.
// dev_irq rises two edges after irq_in; register reads are combinational, writes take effect one edge later.
module dev_pic (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  irq_in,
  input  logic [7:0]  dev_addr,
  input  logic [31:0] dev_in,
  input  logic        we,
  output logic [31:0] dev_out,
  output logic        dev_irq
);

  localparam logic [5:0] A_CTRL  = 6'd0;
  localparam logic [5:0] A_MASK  = 6'd1;
  localparam logic [5:0] A_MODE  = 6'd2;
  localparam logic [5:0] A_PEND  = 6'd3;
  localparam logic [5:0] A_CLAIM = 6'd4;
  localparam logic [5:0] A_COUNT = 6'd5;

  logic        gen;
  logic [5:0]  mask;
  logic [5:0]  mode;
  logic [5:0]  pend;
  logic [31:0] count;
  logic [5:0]  irq_s;
  logic [5:0]  irq_p;

  logic        aligned;
  logic [5:0]  widx;
  logic        wr_ctrl, wr_mask, wr_mode, wr_pend, wr_claim, wr_count;
  logic [5:0]  set;
  logic [5:0]  clr;
  logic [5:0]  claim_clr;
  logic [5:0]  rise;
  logic [2:0]  rise_cnt;
  logic [5:0]  pm;
  logic        claim_vld;
  logic [2:0]  claim_id;

  assign aligned  = (dev_addr[1:0] == 2'b00);
  assign widx     = dev_addr[7:2];
  assign wr_ctrl  = we & aligned & (widx == A_CTRL);
  assign wr_mask  = we & aligned & (widx == A_MASK);
  assign wr_mode  = we & aligned & (widx == A_MODE);
  assign wr_pend  = we & aligned & (widx == A_PEND);
  assign wr_claim = we & aligned & (widx == A_CLAIM);
  assign wr_count = we & aligned & (widx == A_COUNT);

  assign set = (mode & irq_s & ~irq_p) | (~mode & irq_s);

  // ids 6 and 7 shift out of the 6-bit field, so they clear nothing
  assign claim_clr = wr_claim ? (6'd1 << dev_in[2:0]) : 6'd0;
  assign clr       = claim_clr | (wr_pend ? dev_in[5:0] : 6'd0);

  assign rise = set & ~pend;

  always_comb begin
    rise_cnt = 3'd0;
    for (int i = 0; i < 6; i++) begin
      rise_cnt = rise_cnt + {2'b00, rise[i]};
    end
  end

  assign pm        = pend & mask;
  assign claim_vld = |pm;
  assign dev_irq   = gen & claim_vld;

  // downward scan so the lowest pending index wins
  always_comb begin
    claim_id = 3'd0;
    for (int i = 5; i >= 0; i--) begin
      if (pm[i]) claim_id = 3'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gen   <= 1'b0;
      mask  <= 6'd0;
      mode  <= 6'd0;
      pend  <= 6'd0;
      count <= 32'd0;
      irq_s <= 6'd0;
      irq_p <= 6'd0;
    end else begin
      irq_s <= irq_in;
      irq_p <= irq_s;
      pend  <= set | (pend & ~clr);
      if (wr_ctrl) gen  <= dev_in[0];
      if (wr_mask) mask <= dev_in[5:0];
      if (wr_mode) mode <= dev_in[5:0];
      if (wr_count) count <= dev_in;
      else          count <= count + {29'd0, rise_cnt};
    end
  end

  always_comb begin
    dev_out = 32'd0;
    if (aligned) begin
      case (widx)
        A_CTRL:  dev_out = {31'd0, gen};
        A_MASK:  dev_out = {26'd0, mask};
        A_MODE:  dev_out = {26'd0, mode};
        A_PEND:  dev_out = {26'd0, pend};
        A_CLAIM: dev_out = {28'd0, claim_vld, claim_id};
        A_COUNT: dev_out = count;
        default: dev_out = 32'd0;
      endcase
    end
  end

endmodule

// File: doc/dev_pic.md
# dev_pic

Six-line interrupt aggregator on the device bus, directly downstream of `dev_timer` and the other peripherals. It samples each device's `dev_irq` line and latches it into a pending register, using either edge or level mode per line. It applies a mask and a global enable, and drives one combined interrupt line toward CP0's HWInt input. Software reads the highest-priority line and acknowledges it through the same register-mapped device bus interface that every `dev_*` block uses.

## Interface
Parameters: none; six lines, fixed.

- `clk` in 1: single system clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `irq_in` in 6: device interrupt lines. Bit 0 is `dev_timer.dev_irq`. Active-high.
- `dev_addr` in 8: byte address of a register, word-aligned.
- `dev_in` in 32: write data.
- `we` in 1: write strobe. The write commits at the `clk` rising edge.
- `dev_out` out 32: read data. Combinational from `dev_addr` and the register state.
- `dev_irq` out 1: combined interrupt to CP0. Equals `CTRL.gen & |(PEND & MASK)`.

## Operation
Register map. Only bit fields shown are stored; other bits read 0.
- 0x00 CTRL [0] `gen`: global enable. Read/write.
- 0x04 MASK [5:0]: 1 = line enabled. Read/write.
- 0x08 MODE [5:0]: 1 = rising-edge mode, 0 = level mode. Read/write.
- 0x0C PEND [5:0]
  - Read returns the pending bits.
  - Write is write-1-to-clear.
- 0x10 CLAIM
  - Read returns {28'b0, valid, id[2:0]}. `id` is the lowest index set in PEND&MASK. `valid` = |(PEND&MASK). When `valid` = 0, `id` = 0.
  - Write clears PEND[`dev_in[2:0]`] if that value is < 6; values 6 and 7 are ignored.
- 0x14 COUNT [31:0]: number of PEND bits that went 0→1. Read/write.
- Any other address, including addresses with `dev_addr[1:0]` ≠ 0: reads 0, writes ignored.

Input sampling:
- `irq_s` <= `irq_in` on every edge.
- `irq_p` <= `irq_s` on every edge.
- Set term per line: `set[i] = MODE[i] ? (irq_s[i] & ~irq_p[i]) : irq_s[i]`.

Pending update per edge:
- `PEND[i]` <= `set[i] | (PEND[i] & ~clr[i])`.
- `clr` comes from a PEND W1C write or a CLAIM write in that cycle.
- Set always wins over clear. A level line that is still high therefore stays pending after acknowledge.
- Pending latches regardless of MASK and `gen`. MASK and `gen` gate only `dev_irq` and CLAIM.
- Writes to MODE, MASK and CTRL never modify PEND.

COUNT:
- Increments by popcount(`set & ~PEND`), 0..6, per edge. Wraps modulo 2^32.
- A COUNT write in the same cycle overrides the increment.

Writes: one register per cycle, selected by `dev_addr`.

## Timing
- Reset (async): CTRL, MASK, MODE, PEND, COUNT, `irq_s` and `irq_p` all clear to 0. `dev_irq` = 0 immediately. `dev_out` = 0 at every address.
- Reset asserted mid-operation discards all pending state at once. There is no pending carry-over after release.
- Latency from `irq_in` to `dev_irq`:
  - `irq_in[i]` high at edge E0 gives `irq_s` = 1 after E0.
  - `PEND[i]` sets and `dev_irq` rises after E1: 2 edges.
  - Edge mode requires `irq_s` low for at least one edge before the rise. A 1-cycle pulse is captured.
- Acknowledge latency:
  - A CLAIM or PEND write at edge E clears the bit after E.
  - `dev_irq` falls in the same cycle if no other masked bit is pending.
- MASK, CTRL and MODE writes affect `dev_irq` and CLAIM from the cycle after the write edge.
- Reads have no side effects.

## Test plan
1. **Reset:** assert `rst` while PEND = 0x3F and `dev_irq` = 1 → `dev_irq` drops at once; all six registers read 0 after release.
2. **Timer edge path:**
   - Stimulus: MODE = 0x01, MASK = 0x01, CTRL = 1, then a 1-cycle pulse on `irq_in[0]`.
   - Response: `dev_irq` rises 2 edges after sampling; PEND = 0x01; CLAIM = 0x8; COUNT = 1.
   - Then write CLAIM = 0 → PEND = 0 and `dev_irq` = 0 the next cycle.
3. **Level hold:**
   - Stimulus: MODE = 0, MASK = 0x04, `gen` = 1, `irq_in[2]` held high, then write PEND = 0x04.
   - Response: PEND stays 0x04 and COUNT stays 1.
   - Deassert `irq_in[2]` for 2 cycles and write PEND = 0x04 again → PEND = 0.
4. **Priority/mask:** PEND = 0x0A.
   - MASK = 0x3F → CLAIM = 0x9.
   - MASK = 0x3D → CLAIM = 0xB.
   - MASK = 0 → CLAIM = 0, `dev_irq` = 0, PEND still 0x0A.
   - CTRL = 0 with MASK = 0x3F → `dev_irq` = 0.
5. **Simultaneous events:**
   - A rising edge on line 4 in the same edge as a PEND = 0x10 write → PEND[4] = 1 and COUNT increments.
   - Edges on lines 1 and 3 on the same edge → COUNT += 2.
   - COUNT = 0xFFFFFFFF followed by one new edge → COUNT = 0.
6. **Bad address/claim:**
   - Write to 0x18 or 0x05 → no register changes and reads give 0.
   - CLAIM write of 7 → PEND unchanged.
